// File: rtl/raven_pkg.sv
// Shared types for the PE row: per-PE operation select and scheduler states.
package raven_pkg;

  typedef enum logic [1:0] {
    GEMM = 2'b00,
    DIV  = 2'b01,
    EXP  = 2'b10,
    LOG  = 2'b11
  } gemm_uno_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } sched_state_e;

endpackage

// File: rtl/pe_op_sched_vld_delay.sv
// Valid tracker mirroring the PE row pipeline: DEPTH-cycle 1-bit delay with sync clear.
module vld_delay #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q,
  output logic any_vld
);

  logic [DEPTH-1:0] sr;
  logic [DEPTH:0]   chain;

  assign chain = {sr, d};

  always_ff @(posedge clk) begin
    if (clear) sr <= '0;
    else       sr <= chain[DEPTH-1:0];
  end

  assign q = sr[DEPTH-1];
  // High while any valid will still be inside the pipe after the coming edge.
  assign any_vld = |chain[DEPTH-1:0];

endmodule

// File: rtl/pe_op_sched.sv
// Operation scheduler for one PE row: weight preload, operand streaming, result drain.
module pe_op_sched
  import raven_pkg::*;
#(
  parameter int unsigned PE_NUM   = 4,
  parameter int unsigned LEN_BW   = 16,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [LEN_BW-1:0] cmd_len_i,
  input  logic              in_empty_i,
  output logic              in_rd_o,
  output logic              w_shift_o,
  output logic [1:0]        gemm_uno_o,
  output logic              out_vld_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned LD_BW = $clog2(PE_NUM + 1);

  sched_state_e      state, state_d;
  logic [LEN_BW-1:0] len_q;
  logic [LEN_BW-1:0] rd_cnt;
  logic [LD_BW-1:0]  ld_cnt;
  logic              accept;
  logic              last_rd;
  logic              ld_last;
  logic              pipe_busy;

  assign accept  = cmd_valid_i & cmd_ready_o;
  assign in_rd_o = (state == STREAM) & ~in_empty_i;
  assign last_rd = in_rd_o & ((rd_cnt + LEN_BW'(1)) == len_q);
  assign ld_last = (ld_cnt == LD_BW'(PE_NUM - 1));

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_len_i == '0)            state_d = DONE;
          else if (cmd_op_i == 2'(GEMM))  state_d = LOAD;
          else                            state_d = STREAM;
        end
      end
      LOAD:    if (ld_last)    state_d = STREAM;
      STREAM:  if (last_rd)    state_d = DRAIN;
      DRAIN:   if (!pipe_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      rd_cnt      <= '0;
      ld_cnt      <= '0;
      gemm_uno_o  <= 2'(GEMM);
      cmd_ready_o <= 1'b1;
      w_shift_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_d;
      cmd_ready_o <= (state_d == IDLE);
      w_shift_o   <= (state_d == LOAD);
      busy_o      <= (state_d != IDLE);
      done_o      <= (state_d == DONE);
      if (accept) begin
        gemm_uno_o <= cmd_op_i;
        len_q      <= cmd_len_i;
        rd_cnt     <= '0;
        ld_cnt     <= '0;
      end else begin
        if (state == LOAD) ld_cnt <= ld_cnt + LD_BW'(1);
        if (in_rd_o)       rd_cnt <= rd_cnt + LEN_BW'(1);
      end
    end
  end

  vld_delay #(
    .DEPTH (PIPE_LAT)
  ) u_vld_delay (
    .clk     (clk),
    .clear   (rst),
    .d       (in_rd_o),
    .q       (out_vld_o),
    .any_vld (pipe_busy)
  );

endmodule

// File: tb/tb_pe_op_sched.sv
// Directed bench for pe_op_sched: per-cycle traces compared against hand-derived patterns.
module tb_pe_op_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [15:0] cmd_len_i;
  logic        in_empty_i;
  logic        in_rd_o;
  logic        w_shift_o;
  logic [1:0]  gemm_uno_o;
  logic        out_vld_o;
  logic        busy_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] ws_v, rd_v, ov_v, dn_v, bz_v, rdy_v;
  logic [63:0] uno_v;

  always #5 clk = ~clk;

  pe_op_sched #(
    .PE_NUM   (4),
    .LEN_BW   (16),
    .PIPE_LAT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_len_i   (cmd_len_i),
    .in_empty_i  (in_empty_i),
    .in_rd_o     (in_rd_o),
    .w_shift_o   (w_shift_o),
    .gemm_uno_o  (gemm_uno_o),
    .out_vld_o   (out_vld_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected mode-select trace: v0 before cycle c1, v1 until c2, v2 afterwards.
  function automatic logic [63:0] uno_pat(input int n, input int c1, input logic [1:0] v0,
                                          input int c2, input logic [1:0] v1,
                                          input logic [1:0] v2);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < n; c++)
      v[2*c +: 2] = (c < c1) ? v0 : ((c < c2) ? v1 : v2);
    return v;
  endfunction

  // Runs n cycles (cycle 0 = offered accept) and records every output per cycle.
  task automatic run(input int n, input logic [31:0] vmask, input logic [31:0] emask,
                     input logic [31:0] rmask, input logic [1:0] op_a,
                     input logic [15:0] len_a, input logic [1:0] op_b,
                     input logic [15:0] len_b);
    ws_v = '0; rd_v = '0; ov_v = '0; dn_v = '0; bz_v = '0; rdy_v = '0; uno_v = '0;
    for (int c = 0; c < n; c++) begin
      cmd_valid_i = vmask[c];
      cmd_op_i    = (c == 0) ? op_a : op_b;
      cmd_len_i   = (c == 0) ? len_a : len_b;
      in_empty_i  = emask[c];
      rst         = rmask[c];
      @(negedge clk);
      ws_v[c]  = w_shift_o;
      rd_v[c]  = in_rd_o;
      ov_v[c]  = out_vld_o;
      dn_v[c]  = done_o;
      bz_v[c]  = busy_o;
      rdy_v[c] = cmd_ready_o;
      uno_v[2*c +: 2] = gemm_uno_o;
      @(posedge clk);
      #1;
    end
    cmd_valid_i = 1'b0;
    in_empty_i  = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic check_run(input string name, input logic [31:0] ws, input logic [31:0] rd,
                           input logic [31:0] ov, input logic [31:0] dn,
                           input logic [31:0] bz, input logic [31:0] rdy,
                           input logic [63:0] uno);
    chk({name, "_wshift"}, 64'(ws_v), 64'(ws));
    chk({name, "_inrd"},   64'(rd_v), 64'(rd));
    chk({name, "_outvld"}, 64'(ov_v), 64'(ov));
    chk({name, "_done"},   64'(dn_v), 64'(dn));
    chk({name, "_busy"},   64'(bz_v), 64'(bz));
    chk({name, "_ready"},  64'(rdy_v), 64'(rdy));
    chk({name, "_uno"},    uno_v, uno);
  endtask

  initial begin
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'b00; cmd_len_i = '0; in_empty_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  64'(cmd_ready_o), 64'd1);
    chk("rst_uno",    64'(gemm_uno_o),  64'd0);
    chk("rst_inrd",   64'(in_rd_o),     64'd0);
    chk("rst_wshift", 64'(w_shift_o),   64'd0);
    chk("rst_outvld", 64'(out_vld_o),   64'd0);
    chk("rst_busy",   64'(busy_o),      64'd0);
    chk("rst_done",   64'(done_o),      64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // GEMM len=3: LOAD 1-4, reads 5-7, results 9-11, done 12
    run(16, 32'h1, 32'h0, 32'h0, 2'b00, 16'd3, 2'b00, 16'd0);
    check_run("gemm3", 32'h001E, 32'h00E0, 32'h0E00, 32'h1000, 32'h1FFE, 32'hE001,
              uno_pat(16, 16, 2'b00, 16, 2'b00, 2'b00));

    // EXP len=4 with empty input in cycles 2-3
    run(14, 32'h1, 32'h0C, 32'h0, 2'b10, 16'd4, 2'b10, 16'd0);
    check_run("exp4", 32'h0000, 32'h0072, 32'h0720, 32'h0800, 32'h0FFE, 32'h3001,
              uno_pat(14, 1, 2'b00, 14, 2'b10, 2'b10));

    // LOG len=0 then DIV len=2 held valid from cycle 1, accepted in cycle 2
    run(12, 32'h7, 32'h0, 32'h0, 2'b11, 16'd0, 2'b01, 16'd2);
    check_run("b2b", 32'h0000, 32'h0018, 32'h0180, 32'h0202, 32'h03FA, 32'h0C05,
              uno_pat(12, 1, 2'b10, 3, 2'b11, 2'b01));

    // DIV len=8 with reset in cycle 4: in-flight results discarded, no done
    run(14, 32'h1, 32'h0, 32'h10, 2'b01, 16'd8, 2'b01, 16'd0);
    check_run("rststream", 32'h0000, 32'h001E, 32'h0000, 32'h0000, 32'h001E, 32'h3FE1,
              uno_pat(14, 5, 2'b01, 14, 2'b00, 2'b00));

    // GEMM len=2 with a LOG len=1 command held from cycle 1, accepted at IDLE cycle 12
    run(20, 32'h1FFF, 32'h0, 32'h0, 2'b00, 16'd2, 2'b11, 16'd1);
    check_run("busycmd", 32'h0001E, 32'h02060, 32'h20600, 32'h40800, 32'h7EFFE, 32'h81001,
              uno_pat(20, 13, 2'b00, 20, 2'b11, 2'b11));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
